clk_rst_sequencer: RTL

Power-up and run-time sequencer for the BLDC controller's clock/reset resource. After board reset it holds every downstream stage (clock divider, Hall decoder, PWM core) in reset, releases them in a fixed order with programmable gaps, then issues the periodic clock-enable ticks that pace the PWM and Hall sampling logic. A fault request returns everything to reset until the sequencer is restarted. It sits directly after the top-level clock input and feeds every other block's reset and tick enables.

---
 rtl/clk_rst_seq_pkg.sv | 38 +++
 rtl/tick_divider.sv | 37 +++
 rtl/clk_rst_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/clk_rst_seq_pkg.sv
// Shared types for the BLDC clock/reset sequencer: state encoding, stage bit
// positions and the stage-release mask helper.
package clk_rst_seq_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        REL0  = 3'd1,
        REL1  = 3'd2,
        REL2  = 3'd3,
        RUN   = 3'd4,
        FAULT = 3'd7
    } seq_state_e;

    localparam int STG_CLKDIV = 0;
    localparam int STG_HALL   = 1;
    localparam int STG_PWM    = 2;

    // Active-low stage reset pattern driven while in a given state
    function automatic logic [2:0] stage_mask(input seq_state_e s);
        logic [2:0] m;
        m = 3'b000;
        case (s)
            REL0: m[STG_CLKDIV] = 1'b1;
            REL1: begin
                m[STG_CLKDIV] = 1'b1;
                m[STG_HALL]   = 1'b1;
            end
            REL2, RUN: begin
                m[STG_CLKDIV] = 1'b1;
                m[STG_HALL]   = 1'b1;
                m[STG_PWM]    = 1'b1;
            end
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock-enable generator: one-cycle tick every DIV enabled cycles,
// count held at zero while disabled.
module tick_divider #(
    parameter int DIV = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            W    = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_r;
    logic         tick_r;

    // Count enabled cycles and pulse on the wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {W{1'b0}};
            tick_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= {W{1'b0}};
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= {W{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + W'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up / run-time reset sequencer and tick generator for the BLDC controller.
// Define SEQ_WATCHDOG_EN to add the kick_i watchdog that forces FAULT in RUN.
module clk_rst_sequencer
    import clk_rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int PWM_DIV     = 32,
    parameter int HALL_DIV    = 256
`ifdef SEQ_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES = 1024
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fault_i,
    input  logic       restart_i,
`ifdef SEQ_WATCHDOG_EN
    input  logic       kick_i,
`endif
    output logic [2:0] stage_rst_o,
    output logic       pwm_tick_o,
    output logic       hall_tick_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    localparam int                CNT_MAX   = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int                CNT_W     = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    seq_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       stage_rst_r;
    logic             ready_r;
    logic             fault_r;
    logic             fault_s;
    logic             run_en_s;

`ifdef SEQ_WATCHDOG_EN
    localparam int             WD_W    = $clog2(WDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wdog_cnt_r;
    logic            wdog_trip_s;

    // Watchdog counts RUN cycles since entry or the last kick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_r <= {WD_W{1'b0}};
        end else if ((state_r != RUN) || kick_i) begin
            wdog_cnt_r <= {WD_W{1'b0}};
        end else begin
            wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
        end
    end

    // Trip when this cycle would complete WDOG_CYCLES without a kick
    always_comb begin
        wdog_trip_s = 1'b0;
        if ((state_r == RUN) && !kick_i && (wdog_cnt_r == WD_LAST)) begin
            wdog_trip_s = 1'b1;
        end else begin
            wdog_trip_s = 1'b0;
        end
    end

    assign fault_s = fault_i | wdog_trip_s;
`else
    assign fault_s = fault_i;
`endif

    // Dividers drop out on the faulting edge so a coincident tick is suppressed
    assign run_en_s = (state_r == RUN) && !fault_s;

    // Sequencer FSM with registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            stage_rst_r <= 3'b000;
            ready_r     <= 1'b0;
            fault_r     <= 1'b0;
        end else if (fault_s) begin
            state_r     <= FAULT;
            cnt_r       <= {CNT_W{1'b0}};
            stage_rst_r <= 3'b000;
            ready_r     <= 1'b0;
            fault_r     <= 1'b1;
        end else begin
            case (state_r)
                HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        state_r     <= REL0;
                        cnt_r       <= {CNT_W{1'b0}};
                        stage_rst_r <= stage_mask(REL0);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                REL0: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r     <= REL1;
                        cnt_r       <= {CNT_W{1'b0}};
                        stage_rst_r <= stage_mask(REL1);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                REL1: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r     <= REL2;
                        cnt_r       <= {CNT_W{1'b0}};
                        stage_rst_r <= stage_mask(REL2);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                REL2: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r     <= RUN;
                        cnt_r       <= {CNT_W{1'b0}};
                        stage_rst_r <= stage_mask(RUN);
                        ready_r     <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                RUN: begin
                    state_r <= RUN;
                end
                FAULT: begin
                    if (restart_i) begin
                        state_r     <= HOLD;
                        cnt_r       <= {CNT_W{1'b0}};
                        stage_rst_r <= stage_mask(HOLD);
                        fault_r     <= 1'b0;
                    end else begin
                        state_r <= FAULT;
                    end
                end
                default: begin
                    state_r     <= FAULT;
                    cnt_r       <= {CNT_W{1'b0}};
                    stage_rst_r <= 3'b000;
                    ready_r     <= 1'b0;
                    fault_r     <= 1'b1;
                end
            endcase
        end
    end

    tick_divider #(.DIV(PWM_DIV)) u_pwm_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en_s),
        .tick (pwm_tick_o)
    );

    tick_divider #(.DIV(HALL_DIV)) u_hall_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run_en_s),
        .tick (hall_tick_o)
    );

    assign stage_rst_o = stage_rst_r;
    assign ready_o     = ready_r;
    assign fault_o     = fault_r;
    assign state_o     = state_r;

endmodule
